cam_capture: RTL and testbench

CAM_CAPTURE -- requirements
Module: cam_capture

---
 rtl/cam_pkg.sv | 23 ++
 rtl/cam_pixel_pack.sv | 41 ++++
 rtl/cam_capture.sv | 205 ++++++++++++++++++++
 tb/tb_cam_capture.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture block.
//   - pixel format codes as they appear on i_fmt
//   - capture FSM state encoding
//   - packed pixel widths per format
package cam_pkg;

  localparam logic [1:0] FMT_RGB444 = 2'b00;
  localparam logic [1:0] FMT_RGB565 = 2'b01;
  localparam logic [1:0] FMT_RAW8   = 2'b10;

  localparam int RGB444_W  = 12;
  localparam int RGB565_W  = 16;
  localparam int RAW8_W    = 8;
  localparam int PIX_W_MIN = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_ACTIVE,
    ST_DROP
  } cam_state_e;

endpackage

// File: rtl/cam_pixel_pack.sv
// Byte-to-pixel packer (purely combinational).
// Ports:
//   byte_in - byte sampled this cycle
//   b0      - first byte of a two-byte pixel, held from the previous cycle
//   phase   - 0: first byte of pixel, 1: second byte
//   fmt     - latched pixel format (11 behaves as RAW8)
//   pixel   - zero-extended packed pixel
//   valid   - this byte completes a pixel
module cam_pixel_pack
  import cam_pkg::*;
#(
  parameter int PIX_W = 16
) (
  input  logic [7:0]       byte_in,
  input  logic [7:0]       b0,
  input  logic             phase,
  input  logic [1:0]       fmt,
  output logic [PIX_W-1:0] pixel,
  output logic             valid
);

  always_comb begin
    pixel = '0;
    valid = 1'b0;
    case (fmt)
      FMT_RGB444: begin
        valid                 = phase;
        pixel[RGB444_W-1:0]   = {b0[3:0], byte_in};
      end
      FMT_RGB565: begin
        valid                 = phase;
        pixel[RGB565_W-1:0]   = {b0, byte_in};
      end
      default: begin
        valid                 = 1'b1;
        pixel[RAW8_W-1:0]     = byte_in;
      end
    endcase
  end

endmodule

// File: rtl/cam_capture.sv
// Camera parallel-port capture: frames delimited by i_vsync, lines by
// i_href, bytes packed into pixels and pushed to a downstream FIFO.
// Optional crop window enabled by defining CAM_CAPTURE_CROP_EN.
// Ports:
//   i_clk, i_rst          - clock, async active-high reset
//   i_vsync, i_href       - frame / line strobes
//   i_data, i_fmt, i_en   - camera byte, pixel format, capture enable
//   i_full                - downstream FIFO full
//   i_x0/i_x1/i_y0/i_y1   - crop window, inclusive (CAM_CAPTURE_CROP_EN only)
//   o_wr, o_wdata         - pixel write strobe / data (registered)
//   o_sof, o_eol          - start-of-frame / end-of-line pulses
//   o_overflow            - sticky lost-pixel flag, cleared on o_sof
//   o_rows                - line count of the last completed frame
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | not capturing, waiting for vsync rise with i_en=1
// WAIT_SOF | format latched, waiting for vsync fall (frame start)
// ACTIVE   | capturing lines and writing pixels
// DROP     | a pixel was lost to i_full; discard rest of the frame
module cam_capture
  import cam_pkg::*;
#(
  parameter int PIX_W = 16,
  parameter int COL_W = 11,
  parameter int ROW_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vsync,
  input  logic             i_href,
  input  logic [7:0]       i_data,
  input  logic [1:0]       i_fmt,
  input  logic             i_en,
  input  logic             i_full,
`ifdef CAM_CAPTURE_CROP_EN
  input  logic [COL_W-1:0] i_x0,
  input  logic [COL_W-1:0] i_x1,
  input  logic [ROW_W-1:0] i_y0,
  input  logic [ROW_W-1:0] i_y1,
`endif
  output logic             o_wr,
  output logic [PIX_W-1:0] o_wdata,
  output logic             o_sof,
  output logic             o_eol,
  output logic             o_overflow,
  output logic [ROW_W-1:0] o_rows
);

  cam_state_e       state_q, state_d;
  logic             vsync_q, href_q;
  logic [1:0]       fmt_q;
  logic             phase_q;
  logic [7:0]       b0_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;

  logic             vs_rise, vs_fall, href_fall;
  logic             pack_valid, pix_done, in_win;
  logic [PIX_W-1:0] pix;
  logic             frame_start, sof, lose, wr, latch_rows;

  assign vs_rise   = i_vsync & ~vsync_q;
  assign vs_fall   = ~i_vsync & vsync_q;
  assign href_fall = ~i_href & href_q;

  cam_pixel_pack #(.PIX_W(PIX_W)) u_pack (
    .byte_in (i_data),
    .b0      (b0_q),
    .phase   (phase_q),
    .fmt     (fmt_q),
    .pixel   (pix),
    .valid   (pack_valid)
  );

  assign pix_done = (state_q == ST_ACTIVE) && i_href && pack_valid;

`ifdef CAM_CAPTURE_CROP_EN
  logic [COL_W-1:0] x0_q, x1_q;
  logic [ROW_W-1:0] y0_q, y1_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x0_q <= '0;
      x1_q <= '0;
      y0_q <= '0;
      y1_q <= '0;
    end else if (frame_start) begin
      x0_q <= i_x0;
      x1_q <= i_x1;
      y0_q <= i_y0;
      y1_q <= i_y1;
    end
  end

  assign in_win = (col_q >= x0_q) && (col_q <= x1_q) &&
                  (row_q >= y0_q) && (row_q <= y1_q);
`else
  assign in_win = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    sof         = 1'b0;
    lose        = 1'b0;
    wr          = 1'b0;
    latch_rows  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vs_rise && i_en) begin
          state_d     = ST_WAIT_SOF;
          frame_start = 1'b1;
        end
      end
      ST_WAIT_SOF: begin
        if (vs_fall) begin
          state_d = ST_ACTIVE;
          sof     = 1'b1;
        end
      end
      ST_ACTIVE, ST_DROP: begin
        if (vs_rise) begin
          latch_rows = 1'b1;
          if (i_en) begin
            state_d     = ST_WAIT_SOF;
            frame_start = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (pix_done && in_win) begin
          // Out-of-window pixels never count as lost.
          if (i_full) begin
            lose    = 1'b1;
            state_d = ST_DROP;
          end else begin
            wr = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // vsync_q resets high so a release with vsync already high is not
  // mistaken for a frame start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vsync_q    <= 1'b1;
      href_q     <= 1'b0;
      fmt_q      <= FMT_RGB444;
      phase_q    <= 1'b0;
      b0_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      o_wr       <= 1'b0;
      o_wdata    <= '0;
      o_sof      <= 1'b0;
      o_eol      <= 1'b0;
      o_overflow <= 1'b0;
      o_rows     <= '0;
    end else begin
      vsync_q <= i_vsync;
      href_q  <= i_href;
      o_wr    <= wr;
      o_sof   <= sof;
      o_eol   <= (state_q == ST_ACTIVE) && href_fall;

      if (frame_start) fmt_q <= i_fmt;
      if (wr) o_wdata <= pix;
      if (latch_rows) o_rows <= row_q;

      if (sof) o_overflow <= 1'b0;
      else if (lose) o_overflow <= 1'b1;

      if (state_q == ST_ACTIVE && i_href) begin
        if (pack_valid) begin
          phase_q <= 1'b0;
          col_q   <= col_q + COL_W'(1);
        end else begin
          phase_q <= 1'b1;
          b0_q    <= i_data;
        end
      end else begin
        phase_q <= 1'b0;
      end
      if (!i_href) col_q <= '0;

      if (sof) begin
        row_q <= '0;
      end else if (state_q == ST_ACTIVE && href_fall && row_q != '1) begin
        row_q <= row_q + ROW_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
module tb_cam_capture;

  localparam int PIX_W = 16;
  localparam int COL_W = 11;
  localparam int ROW_W = 10;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_vsync = 1'b0;
  logic             i_href = 1'b0;
  logic [7:0]       i_data = '0;
  logic [1:0]       i_fmt = 2'b00;
  logic             i_en = 1'b0;
  logic             i_full = 1'b0;
`ifdef CAM_CAPTURE_CROP_EN
  logic [COL_W-1:0] i_x0 = '0;
  logic [COL_W-1:0] i_x1 = '0;
  logic [ROW_W-1:0] i_y0 = '0;
  logic [ROW_W-1:0] i_y1 = '0;
`endif
  logic             o_wr;
  logic [PIX_W-1:0] o_wdata;
  logic             o_sof;
  logic             o_eol;
  logic             o_overflow;
  logic [ROW_W-1:0] o_rows;

  cam_capture #(.PIX_W(PIX_W), .COL_W(COL_W), .ROW_W(ROW_W)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_vsync    (i_vsync),
    .i_href     (i_href),
    .i_data     (i_data),
    .i_fmt      (i_fmt),
    .i_en       (i_en),
    .i_full     (i_full),
`ifdef CAM_CAPTURE_CROP_EN
    .i_x0       (i_x0),
    .i_x1       (i_x1),
    .i_y0       (i_y0),
    .i_y1       (i_y1),
`endif
    .o_wr       (o_wr),
    .o_wdata    (o_wdata),
    .o_sof      (o_sof),
    .o_eol      (o_eol),
    .o_overflow (o_overflow),
    .o_rows     (o_rows)
  );

  always #5 i_clk = ~i_clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          wr_cnt  = 0;
  int          sof_cnt = 0;
  int          eol_cnt = 0;
  logic [15:0] last_wdata = '0;
  logic [15:0] wr_log [0:63];

  always @(negedge i_clk) begin
    if (o_wr) begin
      wr_log[wr_cnt % 64] <= o_wdata;
      last_wdata          <= o_wdata;
      wr_cnt              <= wr_cnt + 1;
    end
    if (o_sof) sof_cnt <= sof_cnt + 1;
    if (o_eol) eol_cnt <= eol_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic vs_rise();
    i_vsync = 1'b1;
    tick(2);
  endtask

  task automatic vs_fall();
    i_vsync = 1'b0;
    tick(2);
  endtask

  task automatic line(input int n, input logic [7:0] base);
    for (int j = 0; j < n; j++) begin
      i_data = base + 8'(j);
      i_href = 1'b1;
      tick(1);
    end
    i_href = 1'b0;
    tick(3);
  endtask

  int wr_base, sof_base, eol_base;

  initial begin
    // Reset state
    tick(3);
    check("rst_wr", o_wr, 0);
    check("rst_wdata", o_wdata, 0);
    check("rst_sof", o_sof, 0);
    check("rst_eol", o_eol, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_rows", o_rows, 0);
    i_rst = 1'b0;
    tick(2);

    // Bytes while idle never write
    line(4, 8'h11);
    check("idle_nowr", wr_cnt, 0);

    // Frame A: RGB444, F1,23 -> 0x0123 with one-cycle latency
    i_en = 1'b1;
    i_fmt = 2'b00;
    vs_rise();
    line(4, 8'h11);
    check("waitsof_nowr", wr_cnt, 0);
    vs_fall();
    check("sofA", sof_cnt, 1);
    i_data = 8'hF1; i_href = 1'b1;
    tick(1);
    check("rgb444_wr_b0", o_wr, 0);
    i_data = 8'h23;
    tick(1);
    check("rgb444_wr", o_wr, 1);
    check("rgb444_data", o_wdata, 16'h0123);
    i_href = 1'b0;
    tick(1);
    check("rgb444_wr_1cyc", o_wr, 0);
    tick(3);
    check("rgb444_eol", eol_cnt, 1);
    i_fmt = 2'b01;
    vs_rise();
    check("rowsA", o_rows, 1);

    // Frame B: RGB565, 5 rows x 10 bytes
    wr_base = wr_cnt; eol_base = eol_cnt;
    vs_fall();
    for (int r = 0; r < 5; r++) line(10, 8'(r * 16));
    check("rgb565_wr", wr_cnt - wr_base, 25);
    check("rgb565_eol", eol_cnt - eol_base, 5);
    check("rgb565_last", last_wdata, 16'h4849);
    i_fmt = 2'b10;
    vs_rise();
    check("rowsB", o_rows, 5);

    // Frame C: RAW8, mid-frame format change ignored
    wr_base = wr_cnt;
    vs_fall();
    i_fmt = 2'b01;
    i_href = 1'b1;
    i_data = 8'h0A; tick(1);
    check("raw8_wr0", o_wr, 1);
    check("raw8_d0", o_wdata, 16'h000A);
    i_data = 8'h0B; tick(1);
    check("raw8_wr1", o_wr, 1);
    check("raw8_d1", o_wdata, 16'h000B);
    i_data = 8'h0C; tick(1);
    check("raw8_wr2", o_wr, 1);
    check("raw8_d2", o_wdata, 16'h000C);
    i_href = 1'b0;
    tick(3);
    check("raw8_cnt", wr_cnt - wr_base, 3);
    vs_rise();

    // Frame D: RGB565, FIFO full on third pixel
    wr_base = wr_cnt;
    vs_fall();
    for (int j = 0; j < 10; j++) begin
      i_full = (j == 5);
      i_data = 8'h60 + 8'(j);
      i_href = 1'b1;
      tick(1);
    end
    i_full = 1'b0; i_href = 1'b0;
    tick(3);
    check("ovf_set", o_overflow, 1);
    check("ovf_wr", wr_cnt - wr_base, 2);
    check("ovf_last", last_wdata, 16'h6263);
    line(10, 8'h70);
    check("drop_nowr", wr_cnt - wr_base, 2);
    check("ovf_sticky", o_overflow, 1);
    vs_rise();
    check("ovf_kept_rise", o_overflow, 1);

    // Frame E: resumes, flag cleared; odd line drops half pixel
    wr_base = wr_cnt;
    vs_fall();
    check("ovf_clr", o_overflow, 0);
    line(9, 8'h80);
    check("odd_wr", wr_cnt - wr_base, 4);
    check("odd_last", last_wdata, 16'h8687);
    line(4, 8'h90);
    check("phase_rst_wr", wr_cnt - wr_base, 6);
    check("phase_rst_last", last_wdata, 16'h9293);
    i_en = 1'b0;
    vs_rise();
    check("rowsE", o_rows, 2);

    // Enable low at vsync rise: no new frame
    wr_base = wr_cnt; sof_base = sof_cnt;
    vs_fall();
    line(4, 8'hA0);
    check("dis_nosof", sof_cnt - sof_base, 0);
    check("dis_nowr", wr_cnt - wr_base, 0);

    // Reset mid-row
    i_en = 1'b1;
    vs_rise();
    vs_fall();
    i_href = 1'b1;
    i_data = 8'hB0; tick(1);
    i_data = 8'hB1; tick(1);
    i_data = 8'hB2;
    i_rst = 1'b1;
    tick(1);
    check("mrst_wr", o_wr, 0);
    check("mrst_wdata", o_wdata, 0);
    check("mrst_sof", o_sof, 0);
    check("mrst_eol", o_eol, 0);
    check("mrst_ovf", o_overflow, 0);
    check("mrst_rows", o_rows, 0);
    i_rst = 1'b0;
    wr_base = wr_cnt;
    for (int j = 0; j < 4; j++) begin
      i_data = 8'hB3 + 8'(j);
      tick(1);
    end
    i_href = 1'b0;
    tick(3);
    vs_rise();
    line(4, 8'hB8);
    check("mrst_nowr", wr_cnt - wr_base, 0);
    vs_fall();
    line(2, 8'hC0);
    check("mrst_resume_wr", wr_cnt - wr_base, 1);
    check("mrst_resume_d", last_wdata, 16'hC0C1);

`ifdef CAM_CAPTURE_CROP_EN
    // Crop window x=2..3, y=1 on a 5x5 RGB565 frame
    i_x0 = 11'd2; i_x1 = 11'd3; i_y0 = 10'd1; i_y1 = 10'd1;
    vs_rise();
    wr_base = wr_cnt;
    vs_fall();
    for (int r = 0; r < 5; r++) line(10, 8'(r * 16));
    check("crop_wr", wr_cnt - wr_base, 2);
    check("crop_d0", wr_log[wr_base % 64], 16'h1415);
    check("crop_d1", wr_log[(wr_base + 1) % 64], 16'h1617);
    vs_rise();
    check("crop_rows", o_rows, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
